swap_tag_restore: RTL and testbench
===================================

Name: swap_tag_restore

Overview:
- Return-side companion to the operand swap multiplexer in the FPU/CORDIC datapath.
- When operands enter the datapath, the swap select (tag) is pushed into a small FIFO.
- When the paired results come back, the block pops the oldest tag and un-swaps the result pair into original operand order.
- It then presents the pair on a registered valid/ready output stage.

Parameters:
- W, 32, width of each result word.
- DEPTH, 4, tag FIFO depth. Must be a power of two, at least 2.
- AW, 2, pointer width. Must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 means reset.
- tag_push_i  in  1  push tag_i into the FIFO this cycle.
- tag_i  in  1  swap select used on the forward path. 1 = pass-through, 0 = swapped.
- tag_full_o  out  1  FIFO holds DEPTH tags.
- tag_empty_o  out  1  FIFO holds 0 tags.
- res_valid_i  in  1  result pair R0_i/R1_i is valid.
- res_ready_o  out  1  result pair is accepted this cycle.
- R0_i  in  W  result word 0, in datapath order.
- R1_i  in  W  result word 1, in datapath order.
- out_valid_o  out  1  Q0_o/Q1_o hold a restored pair.
- out_ready_i  in  1  downstream accepts the restored pair.
- Q0_o  out  W  restored word 0, in original operand order.
- Q1_o  out  W  restored word 1, in original operand order.
- err_o  out  1  sticky error flag: overflow or underflow.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Pointers and count cleared; tag_empty_o=1, tag_full_o=0.
  - out_valid_o=0, Q0_o=0, Q1_o=0, err_o=0.
  - Reset mid-operation discards all stored tags and any pending output.
- Tag FIFO:
  - Circular buffer of DEPTH one-bit entries, with write pointer wp, read pointer rp and count cnt (AW+1 bits).
  - Pointers wrap modulo DEPTH.
  - tag_full_o = (cnt==DEPTH); tag_empty_o = (cnt==0). Both are registered state, not combinational on the inputs.
- Output stage:
  - out_free = !out_valid_o || out_ready_i.
- Accept:
  - res_ready_o = !tag_empty_o && out_free. This is combinational; it depends on out_ready_i.
  - pop = res_valid_i && res_ready_o.
- Restore, on pop, registered with 1-cycle latency:
  - Popped tag=1: Q0_o<=R0_i, Q1_o<=R1_i.
  - Popped tag=0: Q0_o<=R1_i, Q1_o<=R0_i.
  - out_valid_o<=1.
- Drain:
  - If out_valid_o && out_ready_i && !pop, then out_valid_o<=0.
  - Q0_o/Q1_o keep their last value.
- Hold: while out_valid_o && !out_ready_i, Q0_o/Q1_o/out_valid_o stay stable.
- Push:
  - When tag_push_i && (!tag_full_o || pop): mem[wp]<=tag_i, wp++.
  - A push while full with no pop in the same cycle is dropped, and err_o<=1.
- Simultaneous push and pop:
  - Both take effect and cnt is unchanged.
  - Push at full with a concurrent pop is legal.
- Underflow:
  - res_valid_i=1 while tag_empty_o=1 holds the result; res_ready_o=0.
  - If it persists 2^(AW+2) consecutive cycles, err_o<=1. The check uses an internal stall counter that resets on any pop.
- Empty + push + res_valid in the same cycle: no bypass. The result is accepted one cycle later (see Optional Feature).
- Ordering: tags pop strictly in push order. Results are assumed to return in issue order.
- err_o is cleared only by reset.

Optional Feature:
- Macro: SWAP_TAG_BYPASS_EN.
- Defined:
  - When tag_empty_o=1 and tag_push_i=1, the incoming tag_i is forwarded directly as the restore select.
  - res_ready_o = (!tag_empty_o || tag_push_i) && out_free.
  - A bypassed pop does not write the FIFO; pointers and cnt are unchanged.
  - Zero-latency tag path for 0-cycle datapath configurations.
- Undefined: behaviour exactly as in Behaviour. A tag always spends at least 1 cycle in the FIFO.

Test Plan:
- Pass-through: push tag=1, then 1 cycle later send res_valid with R0=0x3F800000, R1=0x40000000, out_ready=1.
  - Next cycle: Q0=0x3F800000, Q1=0x40000000, out_valid=1.
- Swap restore: push tag=0, send R0=0xAAAA5555, R1=0x12345678.
  - Q0=0x12345678, Q1=0xAAAA5555.
- Fill and order: push tags 1,0,0,1 (DEPTH=4), giving tag_full_o=1; then a 5th push.
  - The 5th push is dropped and err_o=1.
  - Four results with R0=k, R1=k+0x10 (k=1..4) restore as (1,0x11), (0x12,2), (0x13,3), (4,0x14).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and a second result pending.
  - Q0/Q1 stay stable and res_ready_o=0.
  - When out_ready=1, the pending result loads the next cycle with no bubble.
- Push and pop at full: FIFO full, push tag=0 while popping.
  - cnt stays 4, err_o stays 0, and the new tag is popped last.
- Reset mid-flight: 2 tags stored, out_valid=1, then rst=0 for 1 cycle.
  - tag_empty_o=1, out_valid_o=0, Q0_o=Q1_o=0, err_o=0.
  - A subsequent res_valid is not accepted.

Source files
------------

// File: rtl/swap_tag_restore.sv
// ============================================================================
// Module   : swap_tag_restore
// Purpose  : Return-side un-swap of FPU/CORDIC result pairs, using a FIFO of
//            forward-path swap tags and a registered valid/ready output stage.
//            Optional zero-latency tag bypass: SWAP_TAG_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swap_tag_restore #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tag_push_i,
    input  logic         tag_i,
    output logic         tag_full_o,
    output logic         tag_empty_o,
    input  logic         res_valid_i,
    output logic         res_ready_o,
    input  logic [W-1:0] R0_i,
    input  logic [W-1:0] R1_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] Q0_o,
    output logic [W-1:0] Q1_o,
    output logic         err_o
);

    localparam logic [AW:0]   c_full_cnt  = (AW+1)'(DEPTH);
    localparam logic [AW+2:0] c_stall_lim = (AW+3)'((1 << (AW+2)) - 1);

    generate
        if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_param_check
            $error("swap_tag_restore: DEPTH must be a power of two >= 2 and equal 2**AW");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             r_full;
    logic             r_empty;
    logic             r_out_valid;
    logic [W-1:0]     r_q0;
    logic [W-1:0]     r_q1;
    logic             r_err;
    logic [AW+2:0]    r_stall;

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    logic        w_out_free;
    logic        w_tag_avail;
    logic        w_bypass;
    logic        w_pop;
    logic        w_sel;
    logic        w_fifo_pop;
    logic        w_fifo_push;
    logic        w_drop;
    logic        w_stall;
    logic [AW:0] w_cnt_nxt;

`ifdef SWAP_TAG_BYPASS_EN
    // An empty FIFO with a tag arriving this cycle lends that tag straight to the restore mux.
    assign w_bypass    = r_empty && tag_push_i;
    assign w_tag_avail = !r_empty || tag_push_i;
`else
    assign w_bypass    = 1'b0;
    assign w_tag_avail = !r_empty;
`endif

    assign w_out_free  = !r_out_valid || out_ready_i;
    assign res_ready_o = w_tag_avail && w_out_free;
    assign w_pop       = res_valid_i && res_ready_o;
    assign w_sel       = w_bypass ? tag_i : r_mem[r_rp];

    // A bypassed tag is consumed in flight and never touches the FIFO.
    assign w_fifo_pop  = w_pop && !w_bypass;
    assign w_fifo_push = tag_push_i && (!r_full || w_pop) && !(w_bypass && w_pop);
    assign w_drop      = tag_push_i && r_full && !w_pop;
    assign w_stall     = res_valid_i && r_empty && !w_pop;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_fifo_push, w_fifo_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_fifo_push) begin
                r_mem[r_wp] <= tag_i;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == c_full_cnt);
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Restore and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_q0        <= '0;
            r_q1        <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_q0        <= w_sel ? R0_i : R1_i;
            r_q1        <= w_sel ? R1_i : R0_i;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Error detection: dropped push, or a result starved of tags too long
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_stall <= '0;
            end else if (r_stall != c_stall_lim) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_drop || (w_stall && (r_stall == c_stall_lim))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tag_full_o  = r_full;
    assign tag_empty_o = r_empty;
    assign out_valid_o = r_out_valid;
    assign Q0_o        = r_q0;
    assign Q1_o        = r_q1;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_swap_tag_restore.sv
// ============================================================================
// Module   : tb_swap_tag_restore
// Purpose  : Directed self-checking bench for swap_tag_restore.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swap_tag_restore;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         tag_push_i;
    logic         tag_i;
    logic         tag_full_o;
    logic         tag_empty_o;
    logic         res_valid_i;
    logic         res_ready_o;
    logic [W-1:0] R0_i;
    logic [W-1:0] R1_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] Q0_o;
    logic [W-1:0] Q1_o;
    logic         err_o;

    int n_cmp;
    int n_bad;

    swap_tag_restore #(.W(W), .DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tag_push_i (tag_push_i),
        .tag_i      (tag_i),
        .tag_full_o (tag_full_o),
        .tag_empty_o(tag_empty_o),
        .res_valid_i(res_valid_i),
        .res_ready_o(res_ready_o),
        .R0_i       (R0_i),
        .R1_i       (R1_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .Q0_o       (Q0_o),
        .Q1_o       (Q1_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tag_push_i = 1'b0; tag_i = 1'b0; res_valid_i = 1'b0;
        R0_i = '0; R1_i = '0; out_ready_i = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    task automatic push_tag(input logic t);
        tag_push_i = 1'b1; tag_i = t;
        tick();
        tag_push_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tag_push_i = 1'b0; tag_i = 1'b0; res_valid_i = 1'b0;
        R0_i = '0; R1_i = '0; out_ready_i = 1'b0;
        tick(); tick();
        n_cmp++; if (tag_empty_o !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", tag_empty_o); end
        n_cmp++; if (tag_full_o !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", tag_full_o); end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (Q0_o !== 32'h0 || Q1_o !== 32'h0) begin n_bad++; $display("FAIL rst_q: got %h %h want 0 0", Q0_o, Q1_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        rst = 1'b1;
    endtask

    task automatic test_pass_through;
        do_reset();
        push_tag(1'b1);
        out_ready_i = 1'b1; res_valid_i = 1'b1;
        R0_i = 32'h3F800000; R1_i = 32'h40000000;
        #1;
        n_cmp++; if (res_ready_o !== 1'b1) begin n_bad++; $display("FAIL pt_ready: got %b want 1", res_ready_o); end
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL pt_valid: got %b want 1", out_valid_o); end
        n_cmp++; if (Q0_o !== 32'h3F800000 || Q1_o !== 32'h40000000) begin n_bad++; $display("FAIL pt_q: got %h %h want 3f800000 40000000", Q0_o, Q1_o); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0 || tag_empty_o !== 1'b1) begin n_bad++; $display("FAIL pt_drain: valid %b empty %b want 0 1", out_valid_o, tag_empty_o); end
        n_cmp++; if (Q0_o !== 32'h3F800000) begin n_bad++; $display("FAIL pt_hold_q0: got %h want 3f800000", Q0_o); end
    endtask

    task automatic test_swap;
        do_reset();
        push_tag(1'b0);
        res_valid_i = 1'b1; R0_i = 32'hAAAA5555; R1_i = 32'h12345678;
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (Q0_o !== 32'h12345678 || Q1_o !== 32'hAAAA5555) begin n_bad++; $display("FAIL swap_q: got %h %h want 12345678 aaaa5555", Q0_o, Q1_o); end
        n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL swap_valid: got %b want 1", out_valid_o); end
    endtask

    task automatic test_fill_order;
        logic [W-1:0] exp0 [4];
        logic [W-1:0] exp1 [4];
        exp0[0] = 32'h1;  exp1[0] = 32'h11;
        exp0[1] = 32'h12; exp1[1] = 32'h2;
        exp0[2] = 32'h13; exp1[2] = 32'h3;
        exp0[3] = 32'h4;  exp1[3] = 32'h14;
        do_reset();
        push_tag(1'b1); push_tag(1'b0); push_tag(1'b0); push_tag(1'b1);
        n_cmp++; if (tag_full_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL fill_full: full %b err %b want 1 0", tag_full_o, err_o); end
        push_tag(1'b0);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL fill_drop_err: got %b want 1", err_o); end
        out_ready_i = 1'b1; res_valid_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            R0_i = W'(k); R1_i = W'(k + 16);
            tick();
            n_cmp++; if (Q0_o !== exp0[k-1] || Q1_o !== exp1[k-1]) begin n_bad++; $display("FAIL fill_order_%0d: got %h %h want %h %h", k, Q0_o, Q1_o, exp0[k-1], exp1[k-1]); end
        end
        res_valid_i = 1'b0;
        n_cmp++; if (tag_empty_o !== 1'b1) begin n_bad++; $display("FAIL fill_empty: got %b want 1", tag_empty_o); end
    endtask

    task automatic test_backpressure;
        do_reset();
        push_tag(1'b1); push_tag(1'b0);
        out_ready_i = 1'b0; res_valid_i = 1'b1;
        R0_i = 32'hA0; R1_i = 32'hB0;
        tick();
        R0_i = 32'hC0; R1_i = 32'hD0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (res_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_%0d: got %b want 0", i, res_ready_o); end
            tick();
            n_cmp++; if (out_valid_o !== 1'b1 || Q0_o !== 32'hA0 || Q1_o !== 32'hB0) begin n_bad++; $display("FAIL bp_hold_%0d: got %b %h %h want 1 a0 b0", i, out_valid_o, Q0_o, Q1_o); end
        end
        out_ready_i = 1'b1;
        #1;
        n_cmp++; if (res_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", res_ready_o); end
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1 || Q0_o !== 32'hD0 || Q1_o !== 32'hC0) begin n_bad++; $display("FAIL bp_next: got %b %h %h want 1 d0 c0", out_valid_o, Q0_o, Q1_o); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid_o); end
    endtask

    task automatic test_push_pop_full;
        do_reset();
        push_tag(1'b1); push_tag(1'b1); push_tag(1'b1); push_tag(1'b1);
        out_ready_i = 1'b1; res_valid_i = 1'b1;
        R0_i = 32'h100; R1_i = 32'h200;
        tag_push_i = 1'b1; tag_i = 1'b0;
        tick();
        tag_push_i = 1'b0;
        n_cmp++; if (Q0_o !== 32'h100 || Q1_o !== 32'h200) begin n_bad++; $display("FAIL ppf_q: got %h %h want 100 200", Q0_o, Q1_o); end
        n_cmp++; if (tag_full_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL ppf_cnt: full %b err %b want 1 0", tag_full_o, err_o); end
        for (int k = 1; k <= 4; k++) begin
            R0_i = W'(k); R1_i = W'(k + 16);
            tick();
            if (k < 4) begin
                n_cmp++; if (Q0_o !== W'(k) || Q1_o !== W'(k + 16)) begin n_bad++; $display("FAIL ppf_pop_%0d: got %h %h want %h %h", k, Q0_o, Q1_o, W'(k), W'(k + 16)); end
            end else begin
                n_cmp++; if (Q0_o !== 32'h14 || Q1_o !== 32'h4) begin n_bad++; $display("FAIL ppf_last: got %h %h want 14 4", Q0_o, Q1_o); end
            end
        end
        res_valid_i = 1'b0;
        n_cmp++; if (tag_empty_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL ppf_end: empty %b err %b want 1 0", tag_empty_o, err_o); end
    endtask

    task automatic test_no_bypass;
        logic exp_rdy;
`ifdef SWAP_TAG_BYPASS_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        do_reset();
        tag_push_i = 1'b1; tag_i = 1'b0; res_valid_i = 1'b1;
        R0_i = 32'h55; R1_i = 32'h66;
        #1;
        n_cmp++; if (res_ready_o !== exp_rdy) begin n_bad++; $display("FAIL nb_same_cycle: got %b want %b", res_ready_o, exp_rdy); end
        tick();
        tag_push_i = 1'b0;
        if (exp_rdy == 1'b0) begin
            n_cmp++; if (res_ready_o !== 1'b1) begin n_bad++; $display("FAIL nb_next_ready: got %b want 1", res_ready_o); end
            tick();
        end
        res_valid_i = 1'b0;
        n_cmp++; if (Q0_o !== 32'h66 || Q1_o !== 32'h55 || out_valid_o !== 1'b1) begin n_bad++; $display("FAIL nb_q: got %b %h %h want 1 66 55", out_valid_o, Q0_o, Q1_o); end
    endtask

    task automatic test_underflow;
        do_reset();
        res_valid_i = 1'b1; R0_i = 32'h9; R1_i = 32'h8;
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL uf_early: got %b want 0", err_o); end
        n_cmp++; if (res_ready_o !== 1'b0) begin n_bad++; $display("FAIL uf_ready: got %b want 0", res_ready_o); end
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL uf_err: got %b want 1", err_o); end
        tick();
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        out_ready_i = 1'b0;
        push_tag(1'b1); push_tag(1'b0); push_tag(1'b1);
        res_valid_i = 1'b1; R0_i = 32'h77; R1_i = 32'h88;
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1 || tag_empty_o !== 1'b0) begin n_bad++; $display("FAIL mf_pre: valid %b empty %b want 1 0", out_valid_o, tag_empty_o); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (tag_empty_o !== 1'b1 || out_valid_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL mf_state: empty %b valid %b err %b want 1 0 0", tag_empty_o, out_valid_o, err_o); end
        n_cmp++; if (Q0_o !== 32'h0 || Q1_o !== 32'h0) begin n_bad++; $display("FAIL mf_q: got %h %h want 0 0", Q0_o, Q1_o); end
        out_ready_i = 1'b1; res_valid_i = 1'b1;
        #1;
        n_cmp++; if (res_ready_o !== 1'b0) begin n_bad++; $display("FAIL mf_ready: got %b want 0", res_ready_o); end
        tick();
        res_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL mf_no_accept: got %b want 0", out_valid_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_pass_through();
        test_swap();
        test_fill_order();
        test_backpressure();
        test_push_pop_full();
        test_no_bypass();
        test_underflow();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
